midi_msg_parser: RTL and testbench

Byte-stream MIDI message parser placed directly downstream of the MIDI UART receiver in the audio clock domain. It consumes one received byte per valid pulse and tracks status and running status. It assembles channel voice messages and emits single-cycle note-on, note-off, control-change and pitch-bend events with registered payloads for the voice allocator. Real-time bytes are dropped, and SysEx and system-common traffic are swallowed.

---
 rtl/midi_msg_parser.sv | 151 +++++++++++++++
 tb/tb_midi_msg_parser.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI byte-stream parser emitting note, CC and pitch-bend events
module midi_msg_parser #(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic        i_clk_aud,
    input  logic        i_aud_rst,
    input  logic        i_valid,
    input  logic [7:0]  i_midi_byte,
    output logic        o_note_on,
    output logic        o_note_off,
    output logic        o_cc_valid,
    output logic        o_bend_valid,
    output logic [3:0]  o_channel,
    output logic [6:0]  o_note,
    output logic [6:0]  o_velocity,
    output logic [6:0]  o_cc_num,
    output logic [6:0]  o_cc_val,
    output logic [13:0] o_bend
);

    localparam logic [3:0] CHAN_SEL = 4'(CHANNEL);

    typedef enum logic [1:0] {
        NO_STATUS,
        WAIT_D1,
        WAIT_D2,
        SYSEX
    } state_t;

    state_t      state_q;
    logic [7:0]  status_q;
    logic [6:0]  d1_q;
    logic        note_on_q;
    logic        note_off_q;
    logic        cc_valid_q;
    logic        bend_valid_q;
    logic [3:0]  channel_q;
    logic [6:0]  note_q;
    logic [6:0]  velocity_q;
    logic [6:0]  cc_num_q;
    logic [6:0]  cc_val_q;
    logic [13:0] bend_q;

    logic        is_data;
    logic        two_byte;
    logic        chan_ok;
    logic [6:0]  d2;

    // Byte classification and message-shape helpers for the current byte / running status.
    // Program change (0xCn) and channel pressure (0xDn) carry a single data byte.
    assign is_data  = ~i_midi_byte[7];
    assign d2       = i_midi_byte[6:0];
    assign two_byte = (status_q[6:4] != 3'b100) && (status_q[6:4] != 3'b101);
    assign chan_ok  = OMNI || (status_q[3:0] == CHAN_SEL);

    // Parser FSM with registered event strobes and payloads; strobes self-clear every cycle.
    always_ff @(posedge i_clk_aud or posedge i_aud_rst) begin
        if (i_aud_rst) begin
            state_q      <= NO_STATUS;
            status_q     <= 8'h00;
            d1_q         <= 7'h00;
            note_on_q    <= 1'b0;
            note_off_q   <= 1'b0;
            cc_valid_q   <= 1'b0;
            bend_valid_q <= 1'b0;
            channel_q    <= 4'h0;
            note_q       <= 7'h00;
            velocity_q   <= 7'h00;
            cc_num_q     <= 7'h00;
            cc_val_q     <= 7'h00;
            bend_q       <= 14'h2000;
        end else begin
            note_on_q    <= 1'b0;
            note_off_q   <= 1'b0;
            cc_valid_q   <= 1'b0;
            bend_valid_q <= 1'b0;
            if (i_valid) begin
                if (is_data) begin
                    case (state_q)
                        WAIT_D1: begin
                            if (two_byte) begin
                                d1_q    <= i_midi_byte[6:0];
                                state_q <= WAIT_D2;
                            end
                        end
                        WAIT_D2: begin
                            // Running status: stay ready for the next d1 without a new status byte.
                            state_q <= WAIT_D1;
                            if (chan_ok) begin
                                case (status_q[7:4])
                                    4'h8: begin
                                        note_off_q <= 1'b1;
                                        channel_q  <= status_q[3:0];
                                        note_q     <= d1_q;
                                        velocity_q <= d2;
                                    end
                                    4'h9: begin
                                        // Note-on with zero velocity is a note-off by MIDI convention.
                                        note_on_q  <= (d2 != 7'h00);
                                        note_off_q <= (d2 == 7'h00);
                                        channel_q  <= status_q[3:0];
                                        note_q     <= d1_q;
                                        velocity_q <= d2;
                                    end
                                    4'hB: begin
                                        cc_valid_q <= 1'b1;
                                        channel_q  <= status_q[3:0];
                                        cc_num_q   <= d1_q;
                                        cc_val_q   <= d2;
                                    end
                                    4'hE: begin
                                        bend_valid_q <= 1'b1;
                                        channel_q    <= status_q[3:0];
                                        bend_q       <= {d2, d1_q};
                                    end
                                    default: begin
                                    end
                                endcase
                            end
                        end
                        default: begin
                        end
                    endcase
                end else if (i_midi_byte < 8'hF0) begin
                    status_q <= i_midi_byte;
                    state_q  <= WAIT_D1;
                end else if (i_midi_byte == 8'hF0) begin
                    status_q <= 8'h00;
                    state_q  <= SYSEX;
                end else if (i_midi_byte <= 8'hF7) begin
                    status_q <= 8'h00;
                    state_q  <= NO_STATUS;
                end
                // 0xF8-0xFF real-time bytes fall through with no effect.
            end
        end
    end

    assign o_note_on    = note_on_q;
    assign o_note_off   = note_off_q;
    assign o_cc_valid   = cc_valid_q;
    assign o_bend_valid = bend_valid_q;
    assign o_channel    = channel_q;
    assign o_note       = note_q;
    assign o_velocity   = velocity_q;
    assign o_cc_num     = cc_num_q;
    assign o_cc_val     = cc_val_q;
    assign o_bend       = bend_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - scoreboard bench for midi_msg_parser (filtered and omni instances)
module tb_midi_msg_parser;

    typedef struct packed {
        logic [3:0]  ch;
        logic [6:0]  note;
        logic [6:0]  vel;
        logic [6:0]  ccn;
        logic [6:0]  ccv;
        logic [13:0] bend;
    } pay_t;

    typedef struct {
        int   cyc;
        int   kind;
        pay_t pay;
    } exp_t;

    localparam pay_t RESET_PAY = '{ch: 4'd0, note: 7'd0, vel: 7'd0, ccn: 7'd0, ccv: 7'd0, bend: 14'h2000};

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  mbyte;
    logic        on_w   [2];
    logic        off_w  [2];
    logic        cc_w   [2];
    logic        bd_w   [2];
    logic [3:0]  ch_w   [2];
    logic [6:0]  note_w [2];
    logic [6:0]  vel_w  [2];
    logic [6:0]  ccn_w  [2];
    logic [6:0]  ccv_w  [2];
    logic [13:0] bend_w [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] m_rs;
    logic [6:0] m_data[$];
    pay_t       held[2];
    exp_t       q0[$];
    exp_t       q1[$];

    midi_msg_parser #(.CHANNEL(2), .OMNI(1'b0)) dut0 (
        .i_clk_aud(clk), .i_aud_rst(rst), .i_valid(valid), .i_midi_byte(mbyte),
        .o_note_on(on_w[0]), .o_note_off(off_w[0]), .o_cc_valid(cc_w[0]), .o_bend_valid(bd_w[0]),
        .o_channel(ch_w[0]), .o_note(note_w[0]), .o_velocity(vel_w[0]),
        .o_cc_num(ccn_w[0]), .o_cc_val(ccv_w[0]), .o_bend(bend_w[0])
    );

    midi_msg_parser #(.CHANNEL(5), .OMNI(1'b1)) dut1 (
        .i_clk_aud(clk), .i_aud_rst(rst), .i_valid(valid), .i_midi_byte(mbyte),
        .o_note_on(on_w[1]), .o_note_off(off_w[1]), .o_cc_valid(cc_w[1]), .o_bend_valid(bd_w[1]),
        .o_channel(ch_w[1]), .o_note(note_w[1]), .o_velocity(vel_w[1]),
        .o_cc_num(ccn_w[1]), .o_cc_val(ccv_w[1]), .o_bend(bend_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        m_rs = 8'h00;
        m_data.delete();
        q0.delete();
        q1.delete();
        held[0] = RESET_PAY;
        held[1] = RESET_PAY;
    endtask

    // A completed two-byte message: work out which instances see it and what they should show.
    task automatic emit(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2, input int ecyc);
        for (int i = 0; i < 2; i++) begin
            int   kind;
            pay_t p;
            exp_t e;
            if (i == 0 && st[3:0] != 4'd2) continue;
            case (st[7:4])
                4'h8:    kind = 2;
                4'h9:    kind = (d2 != 0) ? 1 : 2;
                4'hB:    kind = 3;
                4'hE:    kind = 4;
                default: kind = 0;
            endcase
            if (kind == 0) continue;
            p    = held[i];
            p.ch = st[3:0];
            if (kind <= 2) begin
                p.note = d1;
                p.vel  = d2;
            end else if (kind == 3) begin
                p.ccn = d1;
                p.ccv = d2;
            end else begin
                p.bend = {d2, d1};
            end
            held[i] = p;
            e.cyc  = ecyc;
            e.kind = kind;
            e.pay  = p;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int ecyc);
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_rs = 8'h00;
            m_data.delete();
            return;
        end
        if (b >= 8'h80) begin
            m_rs = b;
            m_data.delete();
            return;
        end
        if (m_rs == 8'h00) return;
        m_data.push_back(b[6:0]);
        if (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) begin
            m_data.delete();
            return;
        end
        if (m_data.size() < 2) return;
        emit(m_rs, m_data[0], m_data[1], ecyc);
        m_data.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        valid = 1'b1;
        mbyte = b;
        model_byte(b, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid = 1'b0;
        end
    endtask

    task automatic chk_reset(input int i);
        pay_t act;
        logic [3:0] strb;
        act  = {ch_w[i], note_w[i], vel_w[i], ccn_w[i], ccv_w[i], bend_w[i]};
        strb = {on_w[i], off_w[i], cc_w[i], bd_w[i]};
        tests++;
        if (strb != 4'b0 || act != RESET_PAY) begin
            fails++;
            $display("FAIL reset[%0d] strobes=%b pay=%h required strobes=0000 pay=%h", i, strb, act, RESET_PAY);
        end
    endtask

    task automatic mon(input int i);
        int   n;
        int   kind_a;
        pay_t act;
        exp_t e;
        bit   have;
        n      = int'(on_w[i]) + int'(off_w[i]) + int'(cc_w[i]) + int'(bd_w[i]);
        kind_a = on_w[i] ? 1 : off_w[i] ? 2 : cc_w[i] ? 3 : bd_w[i] ? 4 : 0;
        act    = {ch_w[i], note_w[i], vel_w[i], ccn_w[i], ccv_w[i], bend_w[i]};
        have   = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (i == 0) ? q0[0] : q1[0];
        if (n > 0) begin
            tests++;
            if (n != 1) begin
                fails++;
                $display("FAIL onehot[%0d] cyc=%0d strobes=%0d required 1", i, cyc, n);
            end
            tests++;
            if (!have) begin
                fails++;
                $display("FAIL unexpected[%0d] cyc=%0d kind=%0d pay=%h required no event", i, cyc, kind_a, act);
            end else begin
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                if (e.cyc != cyc || e.kind != kind_a || e.pay != act) begin
                    fails++;
                    $display("FAIL event[%0d] cyc=%0d kind=%0d pay=%h required cyc=%0d kind=%0d pay=%h",
                             i, cyc, kind_a, act, e.cyc, e.kind, e.pay);
                end
            end
        end else if (have && e.cyc <= cyc) begin
            tests++;
            fails++;
            $display("FAIL missing[%0d] cyc=%0d no strobe required kind=%0d pay=%h", i, cyc, e.kind, e.pay);
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end else if (!have) begin
            tests++;
            if (act != held[i]) begin
                fails++;
                $display("FAIL hold[%0d] cyc=%0d pay=%h required %h", i, cyc, act, held[i]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    initial begin
        logic [7:0] seq_a[$];
        rst   = 1'b1;
        valid = 1'b0;
        mbyte = 8'h00;
        model_reset();
        #2;
        chk_reset(0);
        chk_reset(1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed sequences: note-on, running status with vel-0 note-off, interleaved real-time CC,
        // filtered and accepted bend, one-byte types, SysEx swallow, abandoned partial message.
        seq_a = '{8'h92, 8'h3C, 8'h64,
                  8'h92, 8'h3C, 8'h64, 8'h40, 8'h00,
                  8'hB1, 8'hFE, 8'h07, 8'hF8, 8'h7F,
                  8'hE3, 8'h00, 8'h40,
                  8'hE2, 8'h7F, 8'h7F,
                  8'hC2, 8'h10, 8'h20, 8'hD2, 8'h05, 8'h06,
                  8'hF0, 8'h7E, 8'h3C, 8'h64, 8'hF7, 8'h3C, 8'h64,
                  8'h92, 8'h3C, 8'h82, 8'h3C, 8'h10,
                  8'hB2, 8'h01, 8'hFA, 8'h02, 8'hA2, 8'h11, 8'h22};
        foreach (seq_a[k]) send(seq_a[k]);
        idle(4);

        // Asynchronous reset mid-message, then a lone data byte must not produce anything.
        send(8'h92);
        send(8'h3C);
        @(posedge clk);
        #3;
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        chk_reset(0);
        chk_reset(1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h64);
        send(8'h22);
        idle(3);

        // Randomized byte stream with occasional idle gaps.
        for (int it = 0; it < 3000; it++) begin
            int r;
            logic [7:0] b;
            logic [3:0] ty;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
            end else if (r < 75) begin
                case ($urandom_range(0, 6))
                    0: ty = 4'h8;
                    1: ty = 4'h9;
                    2: ty = 4'hA;
                    3: ty = 4'hB;
                    4: ty = 4'hC;
                    5: ty = 4'hD;
                    default: ty = 4'hE;
                endcase
                b = {ty, ($urandom_range(0, 2) != 0) ? 4'd2 : 4'($urandom_range(0, 15))};
            end else if (r < 85) begin
                b = 8'hF8 + 8'($urandom_range(0, 7));
            end else if (r < 90) begin
                b = 8'hF0;
            end else if (r < 93) begin
                b = 8'hF7;
            end else begin
                b = 8'hF1 + 8'($urandom_range(0, 5));
            end
            send(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(5);

        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
